// File: rtl/dtfag_seq_ctrl_pkg.sv
// Shared widths, FSM encoding and exponent helper for the DTFAG sequencer.
// RADIX_W mirrors the generator's radix_width define; GRP_W mirrors D_width.
package dtfag_seq_ctrl_pkg;

  localparam int RADIX_W   = 4;
  localparam int NUM_STAGE = 4;
  localparam int GRP_W     = 12;
  localparam int LAT       = 4;
  localparam int STAGE_W   = $clog2(NUM_STAGE);

  localparam logic [GRP_W-1:0]   GRP_LAST   = '1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Tag carried alongside each issue through the latency pipe.
  typedef struct packed {
    logic [STAGE_W-1:0] stage;
    logic               last;
  } tw_tag_t;

  // Twiddle exponent for a group in a stage: the group index shifted up by
  // one radix digit per stage, truncated to the three-digit exponent.
  function automatic logic [GRP_W-1:0] tw_exp(input logic [GRP_W-1:0]   grp,
                                               input logic [STAGE_W-1:0] stage);
    return grp << (RADIX_W * int'(stage));
  endfunction

endpackage

// File: rtl/dtfag_seq_ctrl_if.sv
// Control/handshake and DTFAG-facing bundle of the sequencer.
interface dtfag_seq_ctrl_if;
  import dtfag_seq_ctrl_pkg::*;

  logic               start;
  logic               abort;
  logic               stall;
  logic               busy;
  logic               done;
  logic               ROM_CEN;
  logic [RADIX_W-1:0] DTFAG_i;
  logic [RADIX_W-1:0] DTFAG_t;
  logic [RADIX_W-1:0] DTFAG_j;
  logic [STAGE_W-1:0] stage_idx;
  logic               tw_valid;
  logic [STAGE_W-1:0] tw_stage;
  logic               tw_last;

  modport master (
    output start, abort, stall,
    input  busy, done, ROM_CEN, DTFAG_i, DTFAG_t, DTFAG_j, stage_idx,
           tw_valid, tw_stage, tw_last
  );

  modport slave (
    input  start, abort, stall,
    output busy, done, ROM_CEN, DTFAG_i, DTFAG_t, DTFAG_j, stage_idx,
           tw_valid, tw_stage, tw_last
  );

endinterface

// File: rtl/dtfag_lat_pipe.sv
// LAT-deep valid/tag delay line with synchronous clear; matches the fixed
// latency of the twiddle generator so control lines up with its outputs.
module dtfag_lat_pipe #(
  parameter int LAT = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_tag,
  output logic         out_valid,
  output logic [W-1:0] out_tag
);

  logic [LAT-1:0] vld;
  logic [W-1:0]   tag [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      // NOTE: the tag array is reset as well so tw_stage reads a defined 0 out
      // of reset; a wide data delay line would normally leave its storage unreset.
      for (int k = 0; k < LAT; k++) tag[k] <= '0;
    end else if (clr) begin
      vld <= '0;
      for (int k = 0; k < LAT; k++) tag[k] <= '0;
    end else begin
      vld[0] <= in_valid;
      tag[0] <= in_tag;
      for (int k = 1; k < LAT; k++) begin
        vld[k] <= vld[k-1];
        tag[k] <= tag[k-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_tag   = tag[LAT-1];

endmodule

// File: rtl/dtfag_seq_ctrl.sv
// Sequencer for the 65536-point radix-16 DTFAG: issues one exponent digit
// triple per butterfly group and tracks the generator latency to flag results.
module dtfag_seq_ctrl
  import dtfag_seq_ctrl_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  dtfag_seq_ctrl_if.slave bus
);

  state_t             state, state_n;
  logic [GRP_W-1:0]   grp;
  logic [STAGE_W-1:0] stage;
  logic               issue;
  logic               run_last;
  logic [GRP_W-1:0]   exp_n;

  logic               rom_cen;
  logic [RADIX_W-1:0] dig_i, dig_t, dig_j;
  logic [STAGE_W-1:0] stage_q;
  logic               last_q;

  tw_tag_t            in_tag, out_tag;
  logic               pipe_vld;
  logic               final_out;

  assign issue     = (state == S_RUN) && !bus.stall;
  assign run_last  = (grp == GRP_LAST) && (stage == STAGE_LAST);
  assign exp_n     = tw_exp(grp, stage);
  assign final_out = pipe_vld && out_tag.last;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    // NOTE: the default is assigned first so no path leaves state_n unassigned,
    // which would infer a latch.
    state_n = state;
    if (bus.abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (bus.start) state_n = S_RUN;
        S_RUN:   if (issue && run_last) state_n = S_DRAIN;
        S_DRAIN: if (final_out) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Issue outputs are registered: a RUN cycle without stall drives ROM_CEN=0
  // and the triple for the current group on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp     <= '0;
      stage   <= '0;
      rom_cen <= 1'b1;
      dig_i   <= '0;
      dig_t   <= '0;
      dig_j   <= '0;
      stage_q <= '0;
      last_q  <= 1'b0;
    end else if (bus.abort) begin
      grp     <= '0;
      stage   <= '0;
      rom_cen <= 1'b1;
      dig_i   <= '0;
      dig_t   <= '0;
      dig_j   <= '0;
      stage_q <= '0;
      last_q  <= 1'b0;
    end else if (state == S_IDLE) begin
      rom_cen <= 1'b1;
      if (bus.start) begin
        grp   <= '0;
        stage <= '0;
      end
    end else if (issue) begin
      rom_cen               <= 1'b0;
      {dig_i, dig_t, dig_j} <= exp_n;
      stage_q               <= stage;
      last_q                <= run_last;
      grp                   <= grp + GRP_W'(1);
      if (grp == GRP_LAST) stage <= stage + STAGE_W'(1);
    end else begin
      rom_cen <= 1'b1;
    end
  end

  assign in_tag.stage = stage_q;
  assign in_tag.last  = last_q && !rom_cen;

  dtfag_lat_pipe #(
    .LAT (LAT),
    .W   ($bits(tw_tag_t))
  ) u_lat_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.abort),
    .in_valid  (!rom_cen),
    .in_tag    (in_tag),
    .out_valid (pipe_vld),
    .out_tag   (out_tag)
  );

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DRAIN) && final_out;
  assign bus.ROM_CEN   = rom_cen;
  assign bus.DTFAG_i   = dig_i;
  assign bus.DTFAG_t   = dig_t;
  assign bus.DTFAG_j   = dig_j;
  assign bus.stage_idx = stage_q;
  assign bus.tw_valid  = pipe_vld;
  assign bus.tw_stage  = out_tag.stage;
  assign bus.tw_last   = final_out;

endmodule

// File: tb/tb_dtfag_seq_ctrl.sv
// Directed bench for dtfag_seq_ctrl: full runs with stall, digit mapping,
// stage boundary, abort/restart and asynchronous reset mid-run.
module tb_dtfag_seq_ctrl;
  import dtfag_seq_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dtfag_seq_ctrl_if bus ();

  dtfag_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       v;
    logic [1:0] s;
    logic       l;
  } hent_t;

  hent_t hv [LAT+1];
  int cyc_n = 0, issue_cnt = 0, valid_cnt = 0, done_cnt = 0;
  int first_issue = -1, last_issue = -1, done_cyc = -1;
  int trip_err = 0, pipe_err = 0;
  int m_grp = 0, m_stage = 0;
  int obs_grp = -1, obs_stage = -1;

  // Expected triple: the group's three digits followed by zeros, windowed by stage.
  function automatic logic [11:0] model_trip(input int g, input int s);
    logic [3:0] d [6];
    d[0] = 4'(g >> 8);
    d[1] = 4'(g >> 4);
    d[2] = 4'(g);
    d[3] = '0;
    d[4] = '0;
    d[5] = '0;
    return {d[s], d[s+1], d[s+2]};
  endfunction

  function automatic logic [11:0] trip();
    return {bus.DTFAG_i, bus.DTFAG_t, bus.DTFAG_j};
  endfunction

  task automatic flush();
    for (int k = 0; k <= LAT; k++) hv[k] = '0;
  endtask

  task automatic new_run();
    m_grp       = 0;
    m_stage     = 0;
    issue_cnt   = 0;
    valid_cnt   = 0;
    first_issue = -1;
    last_issue  = -1;
  endtask

  // One clock: sample at the falling edge and update the reference model.
  task automatic cyc();
    hent_t cur;
    @(negedge clk);
    cyc_n++;
    cur       = '0;
    obs_grp   = -1;
    obs_stage = -1;
    if (bus.ROM_CEN === 1'b0) begin
      issue_cnt++;
      if (issue_cnt == 1) first_issue = cyc_n;
      last_issue = cyc_n;
      obs_grp    = m_grp;
      obs_stage  = m_stage;
      if (trip() !== model_trip(m_grp, m_stage) || bus.stage_idx !== 2'(m_stage)) trip_err++;
      cur.v = 1'b1;
      cur.s = 2'(m_stage);
      cur.l = (m_grp == 4095) && (m_stage == 3);
      m_grp = (m_grp + 1) % 4096;
      if (m_grp == 0) m_stage = (m_stage + 1) % 4;
    end
    for (int k = LAT; k > 0; k--) hv[k] = hv[k-1];
    hv[0] = cur;
    if (bus.tw_valid !== hv[LAT].v || bus.tw_last !== hv[LAT].l ||
        (hv[LAT].v && bus.tw_stage !== hv[LAT].s) || bus.done !== hv[LAT].l)
      pipe_err++;
    if (bus.tw_valid === 1'b1) valid_cnt++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
  endtask

  logic [11:0] dig_exp [4];
  int st_cyc, bnd_cyc, stall_c, stall_left, stall_cyc, stall_err, hole_cnt;
  logic [11:0] stall_trip;
  logic got_done, hit;

  initial begin
    dig_exp[0] = 12'h123;
    dig_exp[1] = 12'h230;
    dig_exp[2] = 12'h300;
    dig_exp[3] = 12'h000;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    flush();

    // Reset state
    repeat (2) cyc();
    check("rst_rom_cen", bus.ROM_CEN, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_tw_valid", bus.tw_valid, 0);
    check("rst_trip", trip(), 0);
    check("rst_stage_idx", bus.stage_idx, 0);
    check("rst_tw_stage", bus.tw_stage, 0);
    check("rst_tw_last", bus.tw_last, 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Run 1: stall at grp 50, digit mapping, stage boundary, start ignored in RUN
    new_run();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("r1_busy_after_start", bus.busy, 1);
    bnd_cyc = -100; stall_c = -100; stall_left = 0; stall_cyc = 0; stall_err = 0;
    hole_cnt = 0; got_done = 1'b0; stall_trip = '0;
    for (int n = 0; n < 20000 && !got_done; n++) begin
      cyc();
      bus.start = 1'b0;
      if (obs_grp == 'h123)
        check($sformatf("digit_s%0d", obs_stage), trip(), dig_exp[obs_stage]);
      if (obs_stage == 0 && obs_grp == 4095) begin
        check("bnd_fff", trip(), 12'hfff);
        bnd_cyc = cyc_n;
      end
      if (cyc_n == bnd_cyc + 1) begin
        check("bnd_cen", bus.ROM_CEN, 0);
        check("bnd_stage_idx", bus.stage_idx, 1);
        check("bnd_trip", trip(), 0);
      end
      if (cyc_n == bnd_cyc + LAT)     check("bnd_tw_stage0", bus.tw_stage, 0);
      if (cyc_n == bnd_cyc + LAT + 1) check("bnd_tw_stage1", bus.tw_stage, 1);
      if (stall_left > 0) begin
        if (bus.ROM_CEN !== 1'b1 || trip() !== stall_trip) stall_err++;
        stall_cyc++;
        stall_left--;
        if (stall_left == 0) bus.stall = 1'b0;
      end
      if (obs_stage == 0 && obs_grp == 50) begin
        bus.stall  = 1'b1;
        stall_left = 10;
        stall_c    = cyc_n;
        stall_trip = trip();
      end
      if (cyc_n >= stall_c + 1 + LAT && cyc_n <= stall_c + 10 + LAT && bus.tw_valid === 1'b0)
        hole_cnt++;
      if (obs_stage == 1 && obs_grp == 200) bus.start = 1'b1;
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        check("r1_busy_at_done", bus.busy, 1);
      end
    end
    check("r1_done_seen", got_done, 1);
    check("r1_issues", issue_cnt, 16384);
    check("r1_valids", valid_cnt, 16384);
    check("r1_stall_cycles", stall_cyc, 10);
    check("r1_stall_frozen_err", stall_err, 0);
    check("r1_valid_hole", hole_cnt, 10);
    check("r1_done_after_last", done_cyc - last_issue, LAT);
    cyc();
    check("r1_busy_fall", bus.busy, 0);

    // Run 2: no stall, timing from start to first issue and to done
    new_run();
    bus.start = 1'b1;
    st_cyc = cyc_n;
    cyc();
    bus.start = 1'b0;
    got_done = 1'b0;
    for (int n = 0; n < 20000 && !got_done; n++) begin
      cyc();
      if (bus.done === 1'b1) begin
        got_done = 1'b1;
        check("r2_tw_last_at_done", bus.tw_last, 1);
      end
    end
    check("r2_done_seen", got_done, 1);
    check("r2_first_issue_lat", first_issue - st_cyc, 2);
    check("r2_done_from_first", done_cyc - first_issue, 16383 + LAT);
    check("r2_issues", issue_cnt, 16384);
    check("r2_valids", valid_cnt, 16384);
    cyc();
    check("r2_busy_fall", bus.busy, 0);

    // abort together with start in IDLE: stays idle
    bus.start = 1'b1;
    bus.abort = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_start_busy", bus.busy, 0);
    cyc();
    check("abort_start_cen", bus.ROM_CEN, 1);

    // Run 3: abort at stage 2 grp 7
    new_run();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 10000 && !hit; n++) begin
      cyc();
      if (obs_stage == 2 && obs_grp == 7) hit = 1'b1;
    end
    check("r3_abort_point_hit", hit, 1);
    bus.abort = 1'b1;
    flush();
    cyc();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_cen", bus.ROM_CEN, 1);
    check("abort_tw_valid", bus.tw_valid, 0);
    check("abort_done", bus.done, 0);
    check("abort_stage_idx", bus.stage_idx, 0);
    cyc();

    // Restart after abort begins at stage 0 grp 0
    new_run();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    check("restart_busy", bus.busy, 1);
    cyc();
    check("restart_cen", bus.ROM_CEN, 0);
    check("restart_trip", trip(), 0);
    check("restart_stage_idx", bus.stage_idx, 0);

    // Asynchronous reset at grp 100
    hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      cyc();
      if (obs_stage == 0 && obs_grp == 100) hit = 1'b1;
    end
    check("rst_point_hit", hit, 1);
    check("pre_rst_tw_valid", bus.tw_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cen", bus.ROM_CEN, 1);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_tw_valid", bus.tw_valid, 0);
    flush();
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (LAT + 2) cyc();
    check("idle_after_rst_busy", bus.busy, 0);

    check("done_pulse_count", done_cnt, 2);
    check("triple_model_err", trip_err, 0);
    check("pipe_model_err", pipe_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
